// File: rtl/jk_bank_driver.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// jk_bank_driver
//
// Drives a bank of WIDTH external JK flip-flops through one complete
// excitation / clock / verify cycle per request. Each accepted request:
//   1. Registers the J/_K excitation for the requested operation.
//   2. Snapshots the current ff_q and derives the value the bank should hold
//      afterwards.
//   3. Holds the excitation stable for SETUP_CYC cycles.
//   4. Emits one registered ff_clk pulse.
//   5. Waits SETTLE_CYC cycles.
//   6. Compares ff_q against the expected value and pulses done.
//
// Ports
//   clk        system clock, rising-edge active
//   _mr        synchronous active-low reset
//   req_valid  request present (held until accepted)
//   req_ready  idle, request can be accepted
//   req_op     00 LOAD, 01 TOGGLE, 10 SET, 11 CLEAR
//   req_data   LOAD values
//   req_mask   per-bit enable, 0 = bit held
//   ff_j       J excitation to the bank
//   ff__k      active-low K excitation to the bank
//   ff_clk     registered clock pulse to the bank
//   ff_q       Q feedback from the bank
//   done       one-cycle completion pulse, err/err_bits valid
//   err        any bit of ff_q differed from the expected value
//   err_bits   expected XOR ff_q, held until the next accept or reset
// ---------------------------------------------------------------------------
module jk_bank_driver #(
    parameter int WIDTH      = 8,
    parameter int SETUP_CYC  = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             _mr,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] req_mask,
    output logic [WIDTH-1:0] ff_j,
    output logic [WIDTH-1:0] ff__k,
    output logic             ff_clk,
    input  logic [WIDTH-1:0] ff_q,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_bits
);

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_TOGGLE = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        SETTLE,
        CHECK
    } state_t;

    // J excitation: asserted only for enabled bits that must end up at 1,
    // or must toggle.
    function automatic logic [WIDTH-1:0] excite_j(input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] data,
                                                  input logic [WIDTH-1:0] mask);
        logic [WIDTH-1:0] v;
        case (op)
            OP_LOAD:   v = data;
            OP_TOGGLE: v = '1;
            OP_SET:    v = '1;
            default:   v = '0;
        endcase
        return mask & v;
    endfunction

    // _K is active-low: masked-off bits present K inactive (1) so they hold.
    function automatic logic [WIDTH-1:0] excite_k_n(input logic [1:0]       op,
                                                    input logic [WIDTH-1:0] data,
                                                    input logic [WIDTH-1:0] mask);
        logic [WIDTH-1:0] v;
        case (op)
            OP_LOAD:   v = data;
            OP_SET:    v = '1;
            default:   v = '0;
        endcase
        return ~mask | v;
    endfunction

    function automatic logic [WIDTH-1:0] expect_q(input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] data,
                                                  input logic [WIDTH-1:0] mask,
                                                  input logic [WIDTH-1:0] pre);
        logic [WIDTH-1:0] v;
        case (op)
            OP_LOAD:   v = (data & mask) | (pre & ~mask);
            OP_TOGGLE: v = pre ^ mask;
            OP_SET:    v = pre | mask;
            default:   v = pre & ~mask;
        endcase
        return v;
    endfunction

    state_t           state_q;
    logic [7:0]       cnt_q;
    logic             ready_q;
    logic             clk_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] j_q;
    logic [WIDTH-1:0] k_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] err_bits_q;

    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;
    logic [WIDTH-1:0] exp_d;
    logic [WIDTH-1:0] mism_d;

    assign j_d    = excite_j(req_op, req_data, req_mask);
    assign k_d    = excite_k_n(req_op, req_data, req_mask);
    // ff_q sampled here is the pre-operation snapshot of the bank.
    assign exp_d  = expect_q(req_op, req_data, req_mask, ff_q);
    assign mism_d = exp_q ^ ff_q;

    always_ff @(posedge clk) begin
        if (!_mr) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            clk_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_bits_q <= '0;
            j_q        <= '0;
            k_q        <= '1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        j_q        <= j_d;
                        k_q        <= k_d;
                        exp_q      <= exp_d;
                        err_q      <= 1'b0;
                        err_bits_q <= '0;
                        cnt_q      <= 8'(SETUP_CYC - 1);
                        ready_q    <= 1'b0;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    // ff_clk is raised on the same edge that enters PULSE so
                    // it comes straight from a flop.
                    if (cnt_q == 8'd0) begin
                        clk_q   <= 1'b1;
                        state_q <= PULSE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                PULSE: begin
                    clk_q   <= 1'b0;
                    cnt_q   <= 8'(SETTLE_CYC - 1);
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    if (cnt_q == 8'd0) begin
                        err_bits_q <= mism_d;
                        err_q      <= |mism_d;
                        done_q     <= 1'b1;
                        state_q    <= CHECK;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                CHECK: begin
                    done_q  <= 1'b0;
                    j_q     <= '0;
                    k_q     <= '1;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    clk_q   <= 1'b0;
                    done_q  <= 1'b0;
                    j_q     <= '0;
                    k_q     <= '1;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign ff_clk    = clk_q;
    assign ff_j      = j_q;
    assign ff__k     = k_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_bits  = err_bits_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
`timescale 1ns/1ps
// Randomized and directed bench for jk_bank_driver with a behavioural JK
// flip-flop bank attached to the ff_* pins.
module tb_jk_bank_driver;

    localparam int W   = 8;
    localparam int S   = 1;
    localparam int T   = 2;
    localparam int LAT = S + 1 + T;   // accept edge to done edge

    logic         clk = 1'b0;
    logic         mr_n;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_data;
    logic [W-1:0] req_mask;
    logic [W-1:0] ff_j;
    logic [W-1:0] ff__k;
    logic         ff_clk;
    logic [W-1:0] ff_q;
    logic         done;
    logic         err;
    logic [W-1:0] err_bits;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jk_bank_driver #(.WIDTH(W), .SETUP_CYC(S), .SETTLE_CYC(T)) dut (
        .clk       (clk),
        ._mr       (mr_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_mask  (req_mask),
        .ff_j      (ff_j),
        .ff__k     (ff__k),
        .ff_clk    (ff_clk),
        .ff_q      (ff_q),
        .done      (done),
        .err       (err),
        .err_bits  (err_bits)
    );

    // Behavioural JK bank: responds at the clk edge that sees ff_clk high.
    // stuck0 forces selected Q outputs to read 0.
    logic         bank_clr;
    logic [W-1:0] bank_q;
    logic [W-1:0] bank_nxt;
    logic [W-1:0] stuck0;

    always @(posedge clk) begin
        bank_nxt = bank_q;
        if (ff_clk) begin
            for (int i = 0; i < W; i++) begin
                case ({ff_j[i], ~ff__k[i]})
                    2'b10:   bank_nxt[i] = 1'b1;
                    2'b01:   bank_nxt[i] = 1'b0;
                    2'b11:   bank_nxt[i] = ~bank_q[i];
                    default: bank_nxt[i] = bank_q[i];
                endcase
            end
        end
        if (bank_clr) bank_nxt = '0;
        bank_q <= bank_nxt;
    end

    assign ff_q = bank_q & ~stuck0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
        end
    endtask

    // Reference: bank value an operation should leave behind.
    function automatic logic [W-1:0] ref_exp(input logic [1:0] op, input logic [W-1:0] data,
                                             input logic [W-1:0] mask, input logic [W-1:0] pre);
        case (op)
            2'b00:   return (data & mask) | (pre & ~mask);
            2'b01:   return pre ^ mask;
            2'b10:   return pre | mask;
            default: return pre & ~mask;
        endcase
    endfunction

    // Waits for idle, then presents a request; returns at #1 after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] data,
                         input logic [W-1:0] mask, output logic [W-1:0] pre);
        int w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("idle_wait", {31'd0, req_ready}, 32'd1);
        pre       = ff_q;
        req_op    = op;
        req_data  = data;
        req_mask  = mask;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("accept", {31'd0, req_ready}, 32'd0);
    endtask

    // Follows an accepted operation cycle by cycle, from #1 after the accept edge.
    task automatic follow(input logic [1:0] op, input logic [W-1:0] data,
                          input logic [W-1:0] mask, input logic [W-1:0] pre, input bit noise);
        logic [W-1:0] e, ej, ek;
        e = ref_exp(op, data, mask, pre);
        for (int i = 0; i < W; i++) begin
            if (!mask[i])          begin ej[i] = 1'b0; ek[i] = 1'b1; end
            else if (op == 2'b00)  begin ej[i] = data[i]; ek[i] = data[i]; end
            else if (op == 2'b01)  begin ej[i] = 1'b1; ek[i] = 1'b0; end
            else if (op == 2'b10)  begin ej[i] = 1'b1; ek[i] = 1'b1; end
            else                   begin ej[i] = 1'b0; ek[i] = 1'b0; end
        end
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (noise && k <= LAT) begin
                // Requests while busy must have no effect.
                req_valid = 1'b1;
                req_op    = 2'($urandom_range(3, 0));
                req_data  = 8'($urandom_range(255, 0));
                req_mask  = 8'($urandom_range(255, 0));
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("ff_clk", {31'd0, ff_clk}, {31'd0, k == S});
            chk("done", {31'd0, done}, {31'd0, k == LAT});
            chk("ready", {31'd0, req_ready}, {31'd0, k == LAT + 1});
            if (k <= LAT) begin
                chk("ff_j", {24'd0, ff_j}, {24'd0, ej});
                chk("ff__k", {24'd0, ff__k}, {24'd0, ek});
            end else begin
                chk("idle_j", {24'd0, ff_j}, 32'd0);
                chk("idle_k", {24'd0, ff__k}, 32'hFF);
            end
            if (k < LAT) chk("err_clr", {31'd0, err}, 32'd0);
            if (k == LAT) begin
                chk("ff_q", {24'd0, ff_q}, {24'd0, e & ~stuck0});
                chk("err_bits", {24'd0, err_bits}, {24'd0, e & stuck0});
                chk("err", {31'd0, err}, {31'd0, |(e & stuck0)});
            end
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] data,
                          input logic [W-1:0] mask, input bit noise);
        logic [W-1:0] pre;
        issue(op, data, mask, pre);
        follow(op, data, mask, pre, noise);
    endtask

    initial begin
        logic [W-1:0] pre;
        mr_n      = 1'b0;
        bank_clr  = 1'b1;
        stuck0    = '0;
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_data  = 8'hFF;
        req_mask  = 8'hFF;

        // Reset with a request pending: nothing may be accepted.
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_ready", {31'd0, req_ready}, 32'd1);
            chk("rst_clk", {31'd0, ff_clk}, 32'd0);
            chk("rst_j", {24'd0, ff_j}, 32'd0);
            chk("rst_k", {24'd0, ff__k}, 32'hFF);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_err", {31'd0, err}, 32'd0);
            chk("rst_errb", {24'd0, err_bits}, 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        mr_n      = 1'b1;
        bank_clr  = 1'b0;

        // LOAD 0xA5 into an empty bank.
        run_op(2'b00, 8'hA5, 8'hFF, 1'b0);
        chk("load_a5", {24'd0, ff_q}, 32'hA5);

        // TOGGLE 0x3C on 0xF0.
        run_op(2'b00, 8'hF0, 8'hFF, 1'b0);
        run_op(2'b01, 8'h00, 8'h3C, 1'b1);
        chk("toggle_cc", {24'd0, ff_q}, 32'hCC);

        // SET then CLEAR on 0x0F.
        run_op(2'b00, 8'h0F, 8'hFF, 1'b0);
        run_op(2'b10, 8'h00, 8'h30, 1'b0);
        chk("set_3f", {24'd0, ff_q}, 32'h3F);
        run_op(2'b11, 8'hFF, 8'h03, 1'b0);
        chk("clear_3c", {24'd0, ff_q}, 32'h3C);

        // All-zero mask still pulses and leaves the bank alone.
        run_op(2'b01, 8'hFF, 8'h00, 1'b0);
        chk("zmask_3c", {24'd0, ff_q}, 32'h3C);

        // Bit 2 stuck at 0: SET all from 0x00 must flag bit 2.
        run_op(2'b00, 8'h00, 8'hFF, 1'b0);
        stuck0 = 8'h04;
        run_op(2'b10, 8'h00, 8'hFF, 1'b0);
        chk("stuck_err", {31'd0, err}, 32'd1);
        chk("stuck_bits", {24'd0, err_bits}, 32'h04);
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("err_hold", {31'd0, err}, 32'd1);
            chk("errb_hold", {24'd0, err_bits}, 32'h04);
        end
        stuck0 = '0;
        // Next accept clears the held error (checked inside follow).
        run_op(2'b00, 8'h12, 8'hFF, 1'b0);

        // Reset while PULSE would be active; held request re-accepted after.
        issue(2'b00, 8'h55, 8'hFF, pre);
        @(negedge clk);
        mr_n = 1'b0;
        @(posedge clk);
        #1;
        chk("ab_clk", {31'd0, ff_clk}, 32'd0);
        chk("ab_k", {24'd0, ff__k}, 32'hFF);
        chk("ab_j", {24'd0, ff_j}, 32'd0);
        chk("ab_ready", {31'd0, req_ready}, 32'd1);
        chk("ab_done", {31'd0, done}, 32'd0);
        chk("ab_bank", {24'd0, ff_q}, {24'd0, pre});
        @(negedge clk);
        mr_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ab_reacc", {31'd0, req_ready}, 32'd0);
        follow(2'b00, 8'h55, 8'hFF, pre, 1'b0);
        chk("ab_final", {24'd0, ff_q}, 32'h55);

        // Random operations, some with requests arriving while busy.
        for (int n = 0; n < 30; n++) begin
            run_op(2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)),
                   8'($urandom_range(255, 0)), bit'($urandom_range(1, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/jk_bank_driver.md
JK_BANK_DRIVER -- requirements
Module: jk_bank_driver

Interface
REQ-001 Parameter WIDTH, default 8: number of external JK flip-flops driven, 1..32.
REQ-002 Parameter SETUP_CYC, default 1: clk cycles j/_k are held stable before ff_clk rises, 1..255.
REQ-003 Parameter SETTLE_CYC, default 2: clk cycles after ff_clk falls before ff_q is checked, 1..255.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 _mr  input  1  reset, synchronous and active-low.
REQ-006 req_valid  input  1  request present; must stay stable until accepted.
REQ-007 req_ready  output  1  block idle and able to accept a request.
REQ-008 req_op  input  2  operation: 00 LOAD, 01 TOGGLE, 10 SET, 11 CLEAR.
REQ-009 req_data  input  WIDTH  LOAD values; ignored for other ops.
REQ-010 req_mask  input  WIDTH  per-bit enable; 0 = bit held.
REQ-011 ff_j  output  WIDTH  J excitation to the flip-flop bank.
REQ-012 ff__k  output  WIDTH  active-low K excitation to the flip-flop bank.
REQ-013 ff_clk  output  1  registered clock pulse to the flip-flop bank.
REQ-014 ff_q  input  WIDTH  Q feedback from the flip-flop bank.
REQ-015 done  output  1  one-cycle pulse; operation complete, err/err_bits valid.
REQ-016 err  output  1  ff_q mismatched expected value at check.
REQ-017 err_bits  output  WIDTH  per-bit mismatch, expected XOR ff_q.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, PULSE, SETTLE, CHECK; req_ready SHALL be 1 only in IDLE.
REQ-019 Accept occurs at a rising edge with state IDLE, req_valid=1, _mr=1; the edge SHALL register excitation, snapshot ff_q into pre, compute expected, clear err/err_bits, and enter SETUP.
REQ-020 Per-bit excitation SHALL be: mask 0 -> j=0,_k=1; LOAD -> j=_k=data bit; TOGGLE -> j=1,_k=0; SET -> j=1,_k=1; CLEAR -> j=0,_k=0.
REQ-021 Expected SHALL be: LOAD (data&mask)|(pre&~mask); TOGGLE pre^mask; SET pre|mask; CLEAR pre&~mask.
REQ-022 ff_j/ff__k SHALL remain constant from accept until the edge leaving CHECK, then return to all j=0,_k=1 in IDLE.
REQ-023 SETUP SHALL last exactly SETUP_CYC cycles with ff_clk=0 (down-counter, 8 bits).
REQ-024 PULSE SHALL last exactly one cycle with ff_clk=1; ff_clk SHALL be a flop output, glitch-free.
REQ-025 SETTLE SHALL last exactly SETTLE_CYC cycles with ff_clk=0.
REQ-026 At the edge entering CHECK, err_bits SHALL register expected^ff_q and err SHALL register |(expected^ff_q); done SHALL be 1 for the single CHECK cycle.
REQ-027 Latency: with accept at edge E0, ff_clk is high during [E0+SETUP_CYC, E0+SETUP_CYC+1), done is high during [E0+SETUP_CYC+1+SETTLE_CYC, +1), req_ready returns 1 one edge later.
REQ-028 err and err_bits SHALL hold their values after CHECK until the next accept or reset.
REQ-029 req_valid while not IDLE SHALL be ignored with no side effect; back-to-back requests SHALL be spaced by at least one IDLE cycle.
REQ-030 All-zero mask SHALL still run the full sequence, including the ff_clk pulse, with expected = pre.

Reset
REQ-031 Any rising edge with _mr=0 SHALL force state IDLE, req_ready=1, ff_clk=0, ff_j=0, ff__k=all ones, done=0, err=0, err_bits=0, and counters to 0.
REQ-032 Reset in any state, including PULSE, SHALL drop ff_clk at that edge; the aborted operation SHALL produce no done pulse.
REQ-033 req_valid during reset SHALL not be accepted; first possible accept is the first edge with _mr=1.

Verification (WIDTH=8, SETUP_CYC=1, SETTLE_CYC=2, behavioural JK bank on ff_* with 1-cycle response)
REQ-034 Bank=0x00, LOAD data=0xA5 mask=0xFF -> ff_clk high E0+1 only, done at E0+4, ff_q=0xA5, err=0, err_bits=0x00.
REQ-035 Bank=0xF0, TOGGLE mask=0x3C -> ff_j=0x3C, ff__k=0xC3, final ff_q=0xCC, err=0.
REQ-036 Bank=0x0F, SET mask=0x30 then CLEAR mask=0x03 -> ff_q 0x3F then 0x3C, two done pulses, err=0 both.
REQ-037 Bank bit 2 stuck at 0, SET mask=0xFF from 0x00 -> done with err=1, err_bits=0x04; err held until next accept.
REQ-038 _mr=0 at E0+1 (PULSE) -> ff_clk=0, ff__k=0xFF, ff_j=0x00, req_ready=1 after that edge; no done; held req_valid accepted on first edge after _mr=1.
